// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default 125 MHz timing for the key event controller
package key_pkg;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } evt_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DOWN = 2'd1,
      ST_HELD = 2'd2
   } key_state_e;

   localparam int DEF_DEB_CYC    = 5_000_000;
   localparam int DEF_LONG_CYC   = 125_000_000;
   localparam int DEF_REPEAT_CYC = 25_000_000;

endpackage

// File: rtl/key_event_ctrl_if.sv
// rtl/key_event_ctrl_if.sv - valid/ready key event stream
interface key_event_ctrl_if import key_pkg::*; #(
   parameter int KW = 2
);
   logic          evt_valid;
   logic          evt_ready;
   logic [KW-1:0] evt_key;
   evt_type_e     evt_type;

   modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
   modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_filter.sv
// rtl/key_filter.sv - two-flop synchroniser and debounce counter for one key
module key_filter import key_pkg::*; #(
   parameter int DEB_CYC = DEF_DEB_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_level
);
   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         cnt       <= '0;
         key_level <= 1'b1;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         // any cycle that agrees with the accepted level restarts the run
         if (sync2 == key_level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYC - 1)) begin
            key_level <= sync2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced multi-key press/long/repeat event source
module key_event_ctrl import key_pkg::*; #(
   parameter int NKEYS      = 4,
   parameter int DEB_CYC    = DEF_DEB_CYC,
   parameter int LONG_CYC   = DEF_LONG_CYC,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC,
   parameter int KW         = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NKEYS-1:0]     key_in,
   key_event_ctrl_if.master     evt,
   output logic [NKEYS-1:0]     key_level,
   output logic [NKEYS-1:0]     ovf,
   input  logic                 ovf_clr
);
   localparam int HW = $clog2((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC) + 1;
   localparam int IW = KW + 1;

   key_state_e       st_q   [NKEYS];
   key_state_e       st_d   [NKEYS];
   logic [HW-1:0]    hc_q   [NKEYS];
   logic [HW-1:0]    hc_d   [NKEYS];
   evt_type_e        fire_t [NKEYS];
   evt_type_e        pend_t [NKEYS];
   logic [NKEYS-1:0] fire;
   logic [NKEYS-1:0] pend_v;
   logic [NKEYS-1:0] taken;
   logic [NKEYS-1:0] ovf_set;
   logic [KW-1:0]    rr_q;
   logic [KW-1:0]    gnt_idx;
   logic [KW-1:0]    idx;
   logic [IW-1:0]    idx_w;
   logic             gnt_any;
   logic             load;

   for (genvar k = 0; k < NKEYS; k++) begin : g_key
      key_filter #(.DEB_CYC(DEB_CYC)) u_filter (
         .clk       (clk),
         .rst_n     (rst_n),
         .key_raw   (key_in[k]),
         .key_level (key_level[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NKEYS; k++) begin
            st_q[k] <= ST_IDLE;
            hc_q[k] <= '0;
         end
      end else begin
         st_q <= st_d;
         hc_q <= hc_d;
      end
   end

   // a release seen on a terminal-count cycle wins, so only RELEASE is emitted
   always_comb begin
      st_d = st_q;
      hc_d = hc_q;
      fire = '0;
      for (int k = 0; k < NKEYS; k++) begin
         fire_t[k] = EVT_PRESS;
         case (st_q[k])
            ST_IDLE: begin
               if (!key_level[k]) begin
                  fire[k]   = 1'b1;
                  fire_t[k] = EVT_PRESS;
                  st_d[k]   = ST_DOWN;
                  hc_d[k]   = '0;
               end
            end
            ST_DOWN: begin
               if (key_level[k]) begin
                  fire[k]   = 1'b1;
                  fire_t[k] = EVT_RELEASE;
                  st_d[k]   = ST_IDLE;
               end else if (hc_q[k] == HW'(LONG_CYC - 1)) begin
                  fire[k]   = 1'b1;
                  fire_t[k] = EVT_LONG;
                  st_d[k]   = ST_HELD;
                  hc_d[k]   = '0;
               end else begin
                  hc_d[k] = hc_q[k] + HW'(1);
               end
            end
            ST_HELD: begin
               if (key_level[k]) begin
                  fire[k]   = 1'b1;
                  fire_t[k] = EVT_RELEASE;
                  st_d[k]   = ST_IDLE;
               end else if (hc_q[k] == HW'(REPEAT_CYC - 1)) begin
                  fire[k]   = 1'b1;
                  fire_t[k] = EVT_REPEAT;
                  hc_d[k]   = '0;
               end else begin
                  hc_d[k] = hc_q[k] + HW'(1);
               end
            end
            default: st_d[k] = ST_IDLE;
         endcase
      end
   end

   assign load = !evt.evt_valid || evt.evt_ready;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx_w   = '0;
      idx     = '0;
      for (int i = 0; i < NKEYS; i++) begin
         idx_w = IW'(rr_q) + IW'(i);
         if (idx_w >= IW'(NKEYS)) idx_w = idx_w - IW'(NKEYS);
         idx = idx_w[KW-1:0];
         if (!gnt_any && pend_v[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_comb begin
      taken   = '0;
      ovf_set = '0;
      for (int k = 0; k < NKEYS; k++) begin
         taken[k]   = load && gnt_any && (gnt_idx == KW'(k));
         ovf_set[k] = fire[k] && pend_v[k] && !taken[k];
      end
   end

   // a slot being drained this cycle can be refilled without counting as a drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v <= '0;
         ovf    <= '0;
         for (int k = 0; k < NKEYS; k++) pend_t[k] <= EVT_PRESS;
      end else begin
         ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
         for (int k = 0; k < NKEYS; k++) begin
            if (fire[k]) begin
               if (!pend_v[k] || taken[k]) begin
                  pend_v[k] <= 1'b1;
                  pend_t[k] <= fire_t[k];
               end else if (fire_t[k] == EVT_RELEASE) begin
                  pend_t[k] <= EVT_RELEASE;
               end
            end else if (taken[k]) begin
               pend_v[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt.evt_valid <= 1'b0;
         evt.evt_key   <= '0;
         evt.evt_type  <= EVT_PRESS;
         rr_q          <= '0;
      end else if (load) begin
         evt.evt_valid <= gnt_any;
         if (gnt_any) begin
            evt.evt_key  <= gnt_idx;
            evt.evt_type <= pend_t[gnt_idx];
            rr_q         <= (gnt_idx == KW'(NKEYS - 1)) ? '0 : gnt_idx + KW'(1);
         end
      end
   end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - self-checking bench for key_event_ctrl
module tb_key_event_ctrl;
   import key_pkg::*;

   localparam int NK   = 4;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_in;
   logic [3:0] key_level;
   logic [3:0] ovf;
   logic       ovf_clr;
   logic [0:0] k1_in;
   logic [0:0] k1_level;
   logic [0:0] ovf1;

   key_event_ctrl_if #(.KW(2)) evt_if ();
   key_event_ctrl_if #(.KW(1)) evt1_if ();

   key_event_ctrl #(.NKEYS(4), .DEB_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .KW(2)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .evt(evt_if.master),
      .key_level(key_level), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   key_event_ctrl #(.NKEYS(1), .DEB_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP), .KW(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .key_in(k1_in), .evt(evt1_if.master),
      .key_level(k1_level), .ovf(ovf1), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // reference model: debounce as run length, hold timing as cycle stamps
   bit [3:0] m_s1, m_s2, m_lvl, m_pv, m_ovf;
   int       m_run [NK];
   int       m_mode[NK];
   int       m_mark[NK];
   int       m_pt  [NK];
   bit       m_valid;
   int       m_key, m_type, m_rr;

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_pv = '0; m_ovf = '0;
      for (int k = 0; k < NK; k++) begin
         m_run[k] = 0; m_mode[k] = 0; m_mark[k] = 0; m_pt[k] = 0;
      end
      m_valid = 0; m_key = 0; m_type = 0; m_rr = 0;
   endtask

   task automatic model_step();
      bit ev[NK];
      int et[NK];
      bit ld;
      int g, tk;
      for (int k = 0; k < NK; k++) begin
         ev[k] = 0; et[k] = 0;
         if (m_mode[k] == 0) begin
            if (!m_lvl[k]) begin ev[k] = 1; et[k] = 0; m_mode[k] = 1; m_mark[k] = cyc; end
         end else if (m_lvl[k]) begin
            ev[k] = 1; et[k] = 1; m_mode[k] = 0;
         end else if (cyc - m_mark[k] == (m_mode[k] == 1 ? LONG : REP)) begin
            ev[k] = 1; et[k] = (m_mode[k] == 1) ? 2 : 3; m_mode[k] = 2; m_mark[k] = cyc;
         end
      end
      ld = !m_valid || evt_if.evt_ready;
      g  = -1;
      for (int i = 0; i < NK; i++)
         if (g < 0 && m_pv[(m_rr + i) % NK]) g = (m_rr + i) % NK;
      tk = -1;
      if (ld) begin
         m_valid = (g >= 0);
         if (g >= 0) begin m_key = g; m_type = m_pt[g]; m_rr = (g + 1) % NK; tk = g; end
      end
      if (ovf_clr) m_ovf = '0;
      for (int k = 0; k < NK; k++) begin
         if (ev[k]) begin
            if (!m_pv[k] || tk == k) begin m_pv[k] = 1; m_pt[k] = et[k]; end
            else begin m_ovf[k] = 1; if (et[k] == 1) m_pt[k] = 1; end
         end else if (tk == k) begin
            m_pv[k] = 0;
         end
      end
      for (int k = 0; k < NK; k++) begin
         if (m_s2[k] == m_lvl[k]) m_run[k] = 0;
         else if (m_run[k] == DEB - 1) begin m_lvl[k] = m_s2[k]; m_run[k] = 0; end
         else m_run[k]++;
      end
      m_s2 = m_s1;
      m_s1 = key_in;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   int log_cyc[$], log_key[$], log_typ[$];
   int log1_cyc[$], log1_key[$], log1_typ[$];

   always @(negedge clk) begin
      check("key_level", key_level, m_lvl);
      check("ovf", ovf, m_ovf);
      check("evt_valid", evt_if.evt_valid, m_valid);
      if (m_valid) begin
         check("evt_key", evt_if.evt_key, m_key);
         check("evt_type", evt_if.evt_type, m_type);
      end
      if (evt1_if.evt_valid) check("evt1_key", evt1_if.evt_key, 0);
      if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
         log_cyc.push_back(cyc); log_key.push_back(evt_if.evt_key); log_typ.push_back(evt_if.evt_type);
      end
      if (rst_n && evt1_if.evt_valid && evt1_if.evt_ready) begin
         log1_cyc.push_back(cyc); log1_key.push_back(evt1_if.evt_key); log1_typ.push_back(evt1_if.evt_type);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_evt(input int idx, input int key, input int typ, input int at);
      if (idx >= log_key.size()) begin
         checks++; errors++;
         $display("FAIL evt_missing index=%0d actual_count=%0d", idx, log_key.size());
      end else begin
         check("log_key", log_key[idx], key);
         check("log_type", log_typ[idx], typ);
         check("log_cycle", log_cyc[idx], at);
      end
   endtask

   task automatic expect_evt1(input int idx, input int typ, input int at);
      if (idx >= log1_key.size()) begin
         checks++; errors++;
         $display("FAIL evt1_missing index=%0d actual_count=%0d", idx, log1_key.size());
      end else begin
         check("log1_key", log1_key[idx], 0);
         check("log1_type", log1_typ[idx], typ);
         check("log1_cycle", log1_cyc[idx], at);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int t0, b;
      rst_n = 1'b0; key_in = 4'hF; k1_in = 1'b1; ovf_clr = 1'b0;
      evt_if.evt_ready = 1'b1; evt1_if.evt_ready = 1'b1;
      step(3);
      check("rst_key_level", key_level, 4'hF);
      check("rst_evt_valid", evt_if.evt_valid, 0);
      check("rst_evt_key", evt_if.evt_key, 0);
      check("rst_evt_type", evt_if.evt_type, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      step(5);

      // keys 0,2,3 together, then key 2 alone moves the pointer, then 0 and 3 together
      b = log_key.size(); t0 = cyc;
      key_in = 4'b0010;
      step(12); key_in[2] = 1'b1;
      step(4);  key_in = 4'hF;
      step(20);
      expect_evt(b + 0, 0, 0, t0 + 8);
      expect_evt(b + 1, 2, 0, t0 + 9);
      expect_evt(b + 2, 3, 0, t0 + 10);
      expect_evt(b + 3, 2, 1, t0 + 20);
      expect_evt(b + 4, 3, 1, t0 + 24);
      expect_evt(b + 5, 0, 1, t0 + 25);
      check("batch_count", log_key.size(), b + 6);

      // three-cycle glitch on key 1 is filtered out
      b = log_key.size();
      key_in[1] = 1'b0; step(3); key_in[1] = 1'b1; step(12);
      check("glitch_level", key_level, 4'hF);
      check("glitch_count", log_key.size(), b);

      t0 = cyc;
      key_in[1] = 1'b0; step(8);
      check("press_level", key_level, 4'b1101);
      step(2); key_in[1] = 1'b1; step(16);
      expect_evt(b + 0, 1, 0, t0 + 8);
      expect_evt(b + 1, 1, 1, t0 + 18);
      check("key1_count", log_key.size(), b + 2);

      // key 2 held: long then repeats; release lands on a repeat terminal count
      b = log_key.size(); t0 = cyc;
      key_in[2] = 1'b0; step(60); key_in[2] = 1'b1; step(20);
      expect_evt(b + 0, 2, 0, t0 + 8);
      expect_evt(b + 1, 2, 2, t0 + 28);
      for (int r = 0; r < 4; r++) expect_evt(b + 2 + r, 2, 3, t0 + 36 + 8 * r);
      expect_evt(b + 6, 2, 1, t0 + 68);
      check("hold_count", log_key.size(), b + 7);

      // stalled consumer: PRESS held at output, later events collapse to RELEASE
      evt_if.evt_ready = 1'b0; t0 = cyc;
      key_in[1] = 1'b0; step(40); key_in[1] = 1'b1; step(60);
      check("stall_ovf", ovf, 4'b0010);
      check("stall_valid", evt_if.evt_valid, 1);
      check("stall_key", evt_if.evt_key, 1);
      check("stall_type", evt_if.evt_type, 0);
      b = log_key.size();
      evt_if.evt_ready = 1'b1; step(3);
      expect_evt(b + 0, 1, 0, t0 + 100);
      expect_evt(b + 1, 1, 1, t0 + 101);
      check("stall_count", log_key.size(), b + 2);
      ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
      check("ovf_cleared", ovf, 0);

      // asynchronous reset with an event on the output and another pending
      evt_if.evt_ready = 1'b0;
      key_in = 4'b1100; step(12);
      check("pre_rst_valid", evt_if.evt_valid, 1);
      #2; rst_n = 1'b0; key_in = 4'hF; #1;
      check("async_rst_valid", evt_if.evt_valid, 0);
      check("async_rst_level", key_level, 4'hF);
      step(2); rst_n = 1'b1; evt_if.evt_ready = 1'b1;
      b = log_key.size();
      step(30);
      check("post_rst_count", log_key.size(), b);
      check("post_rst_valid", evt_if.evt_valid, 0);

      // single-key build
      b = log1_key.size(); t0 = cyc;
      k1_in = 1'b0; step(10); k1_in = 1'b1; step(16);
      expect_evt1(b + 0, 0, t0 + 8);
      expect_evt1(b + 1, 1, t0 + 18);
      check("nk1_count", log1_key.size(), b + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Multi-key front-end controller. Synchronises and debounces NKEYS raw push-buttons (active-low, 1 = released).
- Runs a per-key press/long/repeat state machine on each key.
- Round-robin arbitrates the per-key events onto one valid/ready event stream for the menu/command logic.
- Sits between board key pins and the application control FSM.

Parameters:
- NKEYS, 4, number of keys (1..16).
- DEB_CYC, 5000000, consecutive stable cycles required to accept a level change (40 ms at 125 MHz).
- LONG_CYC, 125000000, held cycles after PRESS before the LONG event (1 s).
- REPEAT_CYC, 25000000, cycles between REPEAT events after LONG (200 ms).
- KW, $clog2(NKEYS) (min 1), key index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  NKEYS  raw key pins, 0 = pressed, asynchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event when evt_valid && evt_ready.
- evt_key  out  KW  index of the key that produced the event.
- evt_type  out  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- key_level  out  NKEYS  debounced level, 0 = pressed.
- ovf  out  NKEYS  sticky per-key "event dropped" flag.
- ovf_clr  in  1  single-cycle clear of all ovf bits.

Behaviour:
- Reset values: sync flops = 1, key_level = all 1, evt_valid = 0, evt_key = 0, evt_type = 0, ovf = 0, all counters = 0, all FSMs = IDLE, pending = empty.
- Sync: 2-flop synchroniser per key.
- Filter:
  - Counter clears whenever the synced value equals key_level, and also on the cycle key_level updates.
  - Counter increments while the synced value differs from key_level.
  - key_level takes the synced value on the cycle the counter reaches DEB_CYC-1, i.e. DEB_CYC consecutive differing cycles.
  - A single glitch cycle restarts the count.
- Per-key FSM (cycle after key_level changes):
  - IDLE: key_level falls → PRESS event, hold counter = 0 → DOWN.
  - DOWN: hold counter increments each cycle. Counter reaches LONG_CYC-1 → LONG event, counter = 0 → HELD. key_level rises → RELEASE event → IDLE.
  - HELD: counter reaches REPEAT_CYC-1 → REPEAT event, counter = 0, stay in HELD. key_level rises → RELEASE event → IDLE.
  - A rise on the same cycle as a LONG/REPEAT terminal count emits RELEASE only.
- Pending slot (one per key, holds a type):
  - Event with slot empty: slot filled.
  - Event with slot full, new event RELEASE: overwrite the slot and set ovf[k].
  - Event with slot full, new event not RELEASE: drop it and set ovf[k].
  - Slot freed on the cycle it is loaded into the output register; a new event arriving that same cycle fills the slot, no ovf.
  - ovf_clr clears all ovf bits. A same-cycle set wins over clear.
- Arbiter/output:
  - When the output register is empty, or is being accepted this cycle, load the first pending key at or after rr_ptr (wrapping modulo NKEYS). Then set rr_ptr = granted+1, wrapping NKEYS-1 → 0.
  - evt_valid is registered.
  - evt_key/evt_type stay stable while evt_valid && !evt_ready.
  - Full throughput: one event per cycle with evt_ready held high.
- Latency: synced edge to key_level = DEB_CYC cycles. key_level edge to pending = 1 cycle. Pending to evt_valid = 1 cycle when the output is free.
- Reset mid-operation discards all pending and in-flight events. Keys held through reset produce PRESS after DEB_CYC once reset is released.

Decomposition:
- Shared package key_pkg:
  - evt_type_e enum: PRESS, RELEASE, LONG, REPEAT.
  - FSM state enum: IDLE, DOWN, HELD.
  - Default timing constants for 125 MHz.
- Sub-module key_filter: synchroniser plus debounce counter, one instance per key via generate.
- FSM, pending slots and arbiter stay in the top level.

Test Plan (NKEYS=4, DEB_CYC=4, LONG_CYC=20, REPEAT_CYC=8, evt_ready=1 unless stated):
- Key 1 low for 3 cycles, then high → key_level stays 4'b1111, no event. Key 1 low for 10 cycles → key_level[1]=0, then exactly one {key=1, PRESS}. Key 1 released → {key=1, RELEASE}.
- Key 2 held 60 cycles after debounce → PRESS, LONG 20 cycles after PRESS, REPEAT every 8 cycles (4 REPEATs), then RELEASE on release. Intervals checked exactly.
- Keys 0, 2, 3 debounced on the same cycle, rr_ptr=0 → evt_key order 0, 2, 3 on consecutive cycles. Next simultaneous batch with 0 and 3 → order 3, 0.
- evt_ready=0 for 100 cycles while key 1 is pressed, held to REPEAT and released → output holds PRESS stable throughout, ovf[1]=1. After evt_ready=1 the stream is PRESS then RELEASE. ovf_clr → ovf=0.
- Assert rst_n=0 asynchronously with evt_valid=1 and pending events → evt_valid=0 immediately. After release with all keys high, no events emitted.
- NKEYS=1 build, KW=1 → PRESS/RELEASE sequence correct, evt_key always 0.
